// File: rtl/fp_add_32_if.sv
// Operation bus of the FP-add unit: issue side (in_valid/a/b) and result side (out_valid/z).
// No backpressure: in_valid issues an op that cycle, out_valid marks its result one cycle later.
interface fp_add_32_if;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic [31:0] z;

   modport master (output in_valid, a, b, input out_valid, z);
   modport slave  (input in_valid, a, b, output out_valid, z);
endinterface

// File: rtl/fp_add_32.sv
// IEEE-754 single-precision adder, one registered stage, round-to-nearest-even.
// Denormal inputs and results are flushed to signed zero; no exception flags.
module fp_add_32 (
   input  logic       clk,
   input  logic       rst_n,
   fp_add_32_if.slave bus
);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        sa, sb, sl, ss;
   logic [7:0]  ea, eb, el, es, diff;
   logic [22:0] fa, fb, fl, fs;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
   logic [4:0]  sh, lz;
   logic [49:0] shifted;
   logic [26:0] lg_al, sm_al, norm;
   logic [27:0] sum;
   logic [9:0]  exp_n, exp_r;
   logic        round_up;
   logic [24:0] mant_r;
   logic [22:0] frac_f;
   logic [31:0] res;
   logic        out_valid_q, out_valid_d;
   logic [31:0] z_q, z_d;

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      n = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (v[i]) n = 5'(26 - i);
      end
      return n;
   endfunction

   assign {sa, ea, fa} = bus.a;
   assign {sb, eb, fb} = bus.b;
   assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
   assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
   assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
   assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
   assign a_zero = (ea == 8'h00);
   assign b_zero = (eb == 8'h00);
   assign a_big  = (bus.a[30:0] >= bus.b[30:0]);

   always_comb begin
      sl = a_big ? sa : sb;
      ss = a_big ? sb : sa;
      el = a_big ? ea : eb;
      es = a_big ? eb : ea;
      fl = a_big ? fa : fb;
      fs = a_big ? fb : fa;
      diff = el - es;
      // Shifts of 26 or more leave only the sticky bit of the smaller operand.
      sh = (diff > 8'd26) ? 5'd26 : diff[4:0];
      shifted = {1'b1, fs, 26'd0} >> sh;
      sm_al = {shifted[49:24], |shifted[23:0]};
      lg_al = {1'b1, fl, 3'b000};
      sum = (sl == ss) ? ({1'b0, lg_al} + {1'b0, sm_al})
                       : ({1'b0, lg_al} - {1'b0, sm_al});
      lz = lzc27(sum[26:0]);
      if (sum[27]) begin
         norm  = {sum[27:2], sum[1] | sum[0]};
         exp_n = {2'b00, el} + 10'd1;
      end else begin
         norm  = sum[26:0] << lz;
         exp_n = {2'b00, el} - {5'd0, lz};
      end
      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
      exp_r    = exp_n + {9'd0, mant_r[24]};
      frac_f   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

      if (a_nan || b_nan)           res = QNAN;
      else if (a_inf && b_inf)      res = (sa != sb) ? QNAN : bus.a;
      else if (a_inf)               res = bus.a;
      else if (b_inf)               res = bus.b;
      else if (a_zero && b_zero)    res = {sa & sb, 31'd0};
      else if (a_zero)              res = bus.b;
      else if (b_zero)              res = bus.a;
      else if (sum == 28'd0)        res = 32'h0000_0000;
      else if ($signed(exp_n) < 1)  res = {sl, 31'd0};
      else if ($signed(exp_r) >= 255) res = {sl, 8'hFF, 23'd0};
      else                          res = {sl, exp_r[7:0], frac_f};

      out_valid_d = bus.in_valid;
      z_d         = bus.in_valid ? res : z_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         z_q         <= 32'h0000_0000;
      end else begin
         out_valid_q <= out_valid_d;
         z_q         <= z_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.z         = z_q;
endmodule

// File: tb/tb_fp_add_32.sv
// Bench for fp_add_32: directed vectors with known sums, random operands checked
// against a double-precision reference, and an asynchronous reset mid-stream.
module tb_fp_add_32;
   logic clk;
   logic rst_n;
   fp_add_32_if bus ();

   fp_add_32 u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [63:0] op_q[$];
   logic [31:0] hold_z;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: exact double sum rounded once more to single (RNE), FTZ at the edges.
   function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
      logic sa, sb, g, st, up;
      logic [7:0] ea, eb;
      logic [22:0] fa, fb;
      real ra, rb, r;
      logic [63:0] d;
      int e;
      logic [23:0] m;
      logic [24:0] mr;
      {sa, ea, fa} = a;
      {sb, eb, fb} = b;
      if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return 32'h7FC0_0000;
      if (ea == 8'hFF && eb == 8'hFF) return (sa != sb) ? 32'h7FC0_0000 : a;
      if (ea == 8'hFF) return a;
      if (eb == 8'hFF) return b;
      if (ea == 0 && eb == 0) return {sa & sb, 31'd0};
      if (ea == 0) return b;
      if (eb == 0) return a;
      ra = $bitstoreal({sa, 11'(ea) + 11'd896, fa, 29'd0});
      rb = $bitstoreal({sb, 11'(eb) + 11'd896, fb, 29'd0});
      r = ra + rb;
      if (r == 0.0) return 32'h0000_0000;
      d = $realtobits(r);
      e = int'(d[62:52]) - 896;
      if (e < 1) return {d[63], 31'd0};
      m  = {1'b1, d[51:29]};
      g  = d[28];
      st = |d[27:0];
      up = g & (st | m[0]);
      mr = {1'b0, m} + {24'd0, up};
      if (mr[24]) begin
         e++;
         m = mr[24:1];
      end else begin
         m = mr[23:0];
      end
      if (e >= 255) return {d[63], 8'hFF, 23'd0};
      return {d[63], 8'(e), m[22:0]};
   endfunction

   function automatic logic [31:0] rand_op(input logic [7:0] near_e, input bit use_near);
      int k, t;
      logic s;
      logic [22:0] f;
      k = $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      f = 23'($urandom);
      if (k == 0) return {s, 31'd0};
      if (k == 1) return {s, 8'h00, f | 23'd1};
      if (k == 2) return {s, 8'hFF, 23'd0};
      if (k == 3) return {s, 8'hFF, f | 23'd1};
      if (use_near) t = int'(near_e) + $urandom_range(0, 6) - 3;
      else          t = $urandom_range(1, 254);
      if (t < 1)   t = 1;
      if (t > 254) t = 254;
      return {s, 8'(t), f};
   endfunction

   task automatic issue_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      @(negedge clk);
      bus.a = a;
      bus.b = b;
      bus.in_valid = 1'b1;
      exp_q.push_back(exp);
      op_q.push_back({a, b});
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      issue_exp(a, b, model_add(a, b));
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
   endtask

   // Scoreboard: at posedge+1 the queue holds exactly the op issued the cycle before.
   always @(posedge clk) begin
      logic [31:0] e;
      logic [63:0] op;
      #1;
      if (rst_n) begin
         chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
         if (bus.out_valid && exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            op = op_q.pop_front();
            chk($sformatf("z a=%h b=%h", op[63:32], op[31:0]), bus.z, e);
            hold_z = e;
         end else if (!bus.out_valid) begin
            chk("hold_z", bus.z, hold_z);
         end
      end
   end

   initial begin
      logic [31:0] a, b;
      rst_n = 1'b0;
      hold_z = 32'd0;
      bus.in_valid = 1'b0;
      bus.a = 32'd0;
      bus.b = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_z", bus.z, 32'd0);
      chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      rst_n = 1'b1;
      idle();

      issue_exp(32'h411C0000, 32'h3F100000, 32'h41250000);
      issue_exp(32'h40800000, 32'hBE800000, 32'h40700000);
      issue_exp(32'hC0800000, 32'h3E800000, 32'hC0700000);
      issue_exp(32'h40800000, 32'hC0C80000, 32'hC0100000);
      issue_exp(32'h40800000, 32'hC0800000, 32'h00000000);
      issue_exp(32'hC0800000, 32'hC0804000, 32'hC1002000);
      issue_exp(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
      issue_exp(32'h7F800000, 32'h40400000, 32'h7F800000);
      issue_exp(32'h7F800000, 32'hFF800000, 32'h7FC00000);
      issue_exp(32'hFF800000, 32'hFF800000, 32'hFF800000);
      issue_exp(32'h7FC00001, 32'h3F800000, 32'h7FC00000);
      issue_exp(32'h80000000, 32'h80000000, 32'h80000000);
      issue_exp(32'h00000000, 32'h80000000, 32'h00000000);
      issue_exp(32'h00000000, 32'hC0400000, 32'hC0400000);
      issue_exp(32'h00000001, 32'h3F800000, 32'h3F800000);
      issue_exp(32'h3F800000, 32'h33800000, 32'h3F800000);
      issue_exp(32'h3F800000, 32'h33800001, 32'h3F800001);
      issue_exp(32'h3F800001, 32'h33800000, 32'h3F800002);
      issue_exp(32'h00800001, 32'h80800000, 32'h00000000);
      issue_exp(32'h3F800000, 32'h3F800000, 32'h40000000);
      idle();
      idle();

      // Asynchronous reset with an operation in flight.
      issue_exp(32'h40000000, 32'h40000000, 32'h40800000);
      issue(32'h3FC00000, 32'h3FC00000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_z", bus.z, 32'd0);
      chk("async_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      exp_q.delete();
      op_q.delete();
      hold_z = 32'd0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle();

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         a = rand_op(8'd0, 1'b0);
         if ($urandom_range(0, 9) == 0) b = a ^ 32'h8000_0000;
         else b = rand_op(a[30:23], $urandom_range(0, 1) == 1);
         issue(a, b);
      end
      repeat (3) idle();
      chk("drain_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
